// File: rtl/ps2_event_ctrl_if.sv
// Signal bundle between ps2_event_ctrl and its environment: keyboard-FIFO pop port,
// event stream port and modifier/overflow status. The master view is the controller's side.
interface ps2_event_ctrl_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    kb_data;
  logic          kb_ready;
  logic          kb_overflow;
  logic          kb_nextdata_n;
  logic          evt_valid;
  logic          evt_ready;
  logic [7:0]    evt_code;
  logic          evt_ext;
  logic          evt_brk;
  logic [CW-1:0] evt_count;
  logic          shift;
  logic          ctrl;
  logic          caps;
  logic          ovf;
  logic          clr_ovf;

  modport master (
    input  kb_data, kb_ready, kb_overflow, evt_ready, clr_ovf,
    output kb_nextdata_n, evt_valid, evt_code, evt_ext, evt_brk, evt_count,
           shift, ctrl, caps, ovf
  );

  modport slave (
    output kb_data, kb_ready, kb_overflow, evt_ready, clr_ovf,
    input  kb_nextdata_n, evt_valid, evt_code, evt_ext, evt_brk, evt_count,
           shift, ctrl, caps, ovf
  );
endinterface

// File: rtl/ps2_event_ctrl.sv
// Pops PS/2 scancode bytes, folds E0/F0/E1 prefixes into key events, filters typematic
// repeats, tracks shift/ctrl/caps and buffers events in a small FIFO.
module ps2_event_ctrl #(
  parameter int DEPTH         = 8,
  parameter bit FILTER_REPEAT = 1'b1
) (
  input  logic           clk,
  input  logic           clrn,
  ps2_event_ctrl_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_POP    = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_nextdata_n;
  logic          w_nextdata_n_nxt;
  logic          w_parse;
  logic [7:0]    r_byte;
  logic          r_ext_f;
  logic          r_brk_f;
  logic [2:0]    r_skip;
  logic          r_held_v;
  logic [8:0]    r_held;
  logic          r_shift;
  logic          r_ctrl;
  logic          r_caps;
  logic          r_ovf;
  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_evt;
  logic [8:0]    w_key;
  logic          w_drop_rep;
  logic          w_evt_ok;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state      <= S_IDLE;
      r_nextdata_n <= 1'b1;
      r_byte       <= 8'h00;
    end else begin
      r_state      <= w_state_nxt;
      r_nextdata_n <= w_nextdata_n_nxt;
      if (r_state == S_IDLE && bus.kb_ready) begin
        r_byte <= bus.kb_data;
      end else begin
        r_byte <= r_byte;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = bus.kb_ready ? S_POP : S_IDLE;
      S_POP:    w_state_nxt = S_SETTLE;
      S_SETTLE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_nextdata_n_nxt = (w_state_nxt != S_POP);
    w_parse          = (r_state == S_POP);
  end

  // The latched byte is interpreted during POP; its event reaches the FIFO at the end of POP.
  always_comb begin
    w_evt      = w_parse && (r_skip == 3'd0) && (r_byte != 8'hE0) &&
                 (r_byte != 8'hF0) && (r_byte != 8'hE1);
    w_key      = {r_ext_f, r_byte};
    w_drop_rep = FILTER_REPEAT && w_evt && !r_brk_f && r_held_v && (r_held == w_key);
    w_evt_ok   = w_evt && !w_drop_rep;
    w_pop      = (r_count != {CW{1'b0}}) && bus.evt_ready;
    w_push     = w_evt_ok && ((r_count != FULL) || w_pop);
    w_drop     = w_evt_ok && !w_push;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_ext_f  <= 1'b0;
      r_brk_f  <= 1'b0;
      r_skip   <= 3'd0;
      r_held_v <= 1'b0;
      r_held   <= 9'd0;
      r_shift  <= 1'b0;
      r_ctrl   <= 1'b0;
      r_caps   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_parse) begin
        if (r_skip != 3'd0) begin
          r_skip <= r_skip - 3'd1;
        end else if (r_byte == 8'hE1) begin
          r_skip <= 3'd7;
        end else if (r_byte == 8'hE0) begin
          r_ext_f <= 1'b1;
        end else if (r_byte == 8'hF0) begin
          r_brk_f <= 1'b1;
        end else begin
          r_ext_f <= 1'b0;
          r_brk_f <= 1'b0;
        end
      end
      // Modifiers and held key follow every accepted event, even one the full FIFO drops.
      if (w_evt_ok) begin
        if (!r_brk_f) begin
          r_held_v <= 1'b1;
          r_held   <= w_key;
        end else if (r_held_v && (r_held == w_key)) begin
          r_held_v <= 1'b0;
        end
        if (r_byte == 8'h12 || r_byte == 8'h59) begin
          r_shift <= !r_brk_f;
        end
        if (r_byte == 8'h14) begin
          r_ctrl <= !r_brk_f;
        end
        if (r_byte == 8'h58 && !r_ext_f && !r_brk_f) begin
          r_caps <= !r_caps;
        end
      end
      if (w_drop || bus.kb_overflow) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 10'd0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {r_ext_f, r_brk_f, r_byte};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.kb_nextdata_n = r_nextdata_n;
  assign bus.evt_valid     = (r_count != {CW{1'b0}});
  assign bus.evt_code      = r_mem[r_rd_ptr][7:0];
  assign bus.evt_brk       = r_mem[r_rd_ptr][8];
  assign bus.evt_ext       = r_mem[r_rd_ptr][9];
  assign bus.evt_count     = r_count;
  assign bus.shift         = r_shift;
  assign bus.ctrl          = r_ctrl;
  assign bus.caps          = r_caps;
  assign bus.ovf           = r_ovf;
endmodule

// File: tb/tb_ps2_event_ctrl.sv
// Directed bench: two controllers (repeat filter on / off) fed the same keyboard byte stream.
module tb_ps2_event_ctrl;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_overflow;
  logic       evt_ready;
  logic       clr_ovf;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] kb_q[$];
  logic [9:0] got1[$], got0[$], exp1[$], exp0[$];
  logic       nd_prev = 1'b0;
  logic       nd_double = 1'b0;

  ps2_event_ctrl_if #(.DEPTH(DEPTH)) ifc1 ();
  ps2_event_ctrl_if #(.DEPTH(DEPTH)) ifc0 ();

  assign ifc1.kb_data = kb_data;      assign ifc0.kb_data = kb_data;
  assign ifc1.kb_ready = kb_ready;    assign ifc0.kb_ready = kb_ready;
  assign ifc1.kb_overflow = kb_overflow; assign ifc0.kb_overflow = kb_overflow;
  assign ifc1.evt_ready = evt_ready;  assign ifc0.evt_ready = evt_ready;
  assign ifc1.clr_ovf = clr_ovf;      assign ifc0.clr_ovf = clr_ovf;

  ps2_event_ctrl #(.DEPTH(DEPTH), .FILTER_REPEAT(1'b1)) u_dut1 (.clk(clk), .clrn(clrn), .bus(ifc1));
  ps2_event_ctrl #(.DEPTH(DEPTH), .FILTER_REPEAT(1'b0)) u_dut0 (.clk(clk), .clrn(clrn), .bus(ifc0));

  always #5 clk = ~clk;

  // Keyboard FIFO model: pops on a low kb_nextdata_n seen at the clock edge.
  always @(posedge clk) begin
    if (ifc1.kb_nextdata_n == 1'b0 && kb_q.size() != 0) void'(kb_q.pop_front());
    kb_ready <= (kb_q.size() != 0);
    kb_data  <= (kb_q.size() != 0) ? kb_q[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (ifc1.evt_valid && evt_ready) got1.push_back({ifc1.evt_ext, ifc1.evt_brk, ifc1.evt_code});
    if (ifc0.evt_valid && evt_ready) got0.push_back({ifc0.evt_ext, ifc0.evt_brk, ifc0.evt_code});
    if (ifc1.kb_nextdata_n == 1'b0 && nd_prev) nd_double = 1'b1;
    nd_prev = (ifc1.kb_nextdata_n == 1'b0);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] ev(input logic ext, input logic brk, input logic [7:0] code);
    return {ext, brk, code};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    kb_q.push_back(b);
  endtask

  task automatic settle();
    int b = 0;
    while (kb_q.size() != 0 && b < 300) begin
      tick(1);
      b++;
    end
    if (b >= 300) check_eq("settle_timeout", kb_q.size(), 0);
    tick(3);
  endtask

  task automatic wait_pop();
    int b = 0;
    while (ifc1.kb_nextdata_n != 1'b0 && b < 50) begin
      tick(1);
      b++;
    end
    if (b >= 50) check_eq("pop_timeout", ifc1.kb_nextdata_n, 0);
  endtask

  task automatic drain(input int n);
    evt_ready = 1'b1;
    tick(n);
    evt_ready = 1'b0;
    tick(1);
  endtask

  task automatic check_events(input string tag);
    check_eq({tag, "_n1"}, got1.size(), exp1.size());
    for (int i = 0; i < exp1.size(); i++)
      check_eq($sformatf("%s_f1_%0d", tag, i), (i < got1.size()) ? 32'(got1[i]) : 32'hFFFF_FFFF, 32'(exp1[i]));
    check_eq({tag, "_n0"}, got0.size(), exp0.size());
    for (int i = 0; i < exp0.size(); i++)
      check_eq($sformatf("%s_f0_%0d", tag, i), (i < got0.size()) ? 32'(got0[i]) : 32'hFFFF_FFFF, 32'(exp0[i]));
    got1.delete(); got0.delete(); exp1.delete(); exp0.delete();
  endtask

  initial begin
    clrn = 1'b0; evt_ready = 1'b0; clr_ovf = 1'b0; kb_overflow = 1'b0;
    tick(3);
    check_eq("rst_nextdata_n", ifc1.kb_nextdata_n, 1);
    check_eq("rst_valid", ifc1.evt_valid, 0);
    check_eq("rst_count", ifc1.evt_count, 0);
    check_eq("rst_code", {ifc1.evt_ext, ifc1.evt_brk, ifc1.evt_code}, 0);
    check_eq("rst_mods", {ifc1.shift, ifc1.ctrl, ifc1.caps, ifc1.ovf}, 0);
    clrn = 1'b1;
    tick(2);

    // single make 1C: valid one cycle after the pop cycle, head held while not ready
    send(8'h1C);
    wait_pop();
    check_eq("t1_valid_in_pop", ifc1.evt_valid, 0);
    tick(1);
    check_eq("t1_nd_one_cycle", ifc1.kb_nextdata_n, 1);
    check_eq("t1_valid", ifc1.evt_valid, 1);
    check_eq("t1_head", {ifc1.evt_ext, ifc1.evt_brk, ifc1.evt_code}, 10'h01C);
    tick(3);
    check_eq("t1_head_stable", {ifc1.evt_valid, ifc1.evt_ext, ifc1.evt_brk, ifc1.evt_code}, 11'h41C);
    drain(1);
    check_eq("t1_count_after_pop", ifc1.evt_count, 0);
    exp1.push_back(ev(1'b0, 1'b0, 8'h1C)); exp0.push_back(ev(1'b0, 1'b0, 8'h1C));
    check_events("t1");

    // E0 prefixes and E1 Pause sequence
    send(8'hE0); send(8'hF0); send(8'h75); send(8'hE0); send(8'h75);
    settle();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    settle();
    check_eq("t2_ctrl_untouched", ifc1.ctrl, 0);
    drain(4);
    exp1.push_back(ev(1'b1, 1'b1, 8'h75)); exp1.push_back(ev(1'b1, 1'b0, 8'h75));
    exp0.push_back(ev(1'b1, 1'b1, 8'h75)); exp0.push_back(ev(1'b1, 1'b0, 8'h75));
    check_events("t2");

    // typematic repeats
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    settle();
    check_eq("t3_count1", ifc1.evt_count, 3);
    check_eq("t3_count0", ifc0.evt_count, 5);
    drain(8);
    exp1.push_back(ev(1'b0, 1'b0, 8'h1C)); exp1.push_back(ev(1'b0, 1'b1, 8'h1C)); exp1.push_back(ev(1'b0, 1'b0, 8'h1C));
    for (int i = 0; i < 5; i++) exp0.push_back(ev(1'b0, (i == 3), 8'h1C));
    check_events("t3");

    // modifiers: 12, 58, F0 12, 58
    send(8'h12); settle();
    check_eq("t4_shift_on", {ifc1.shift, ifc0.shift}, 2'b11);
    send(8'h58); settle();
    check_eq("t4_caps_on", {ifc1.caps, ifc0.caps}, 2'b11);
    send(8'hF0); send(8'h12); settle();
    check_eq("t4_shift_off", {ifc1.shift, ifc0.shift}, 2'b00);
    send(8'h58); settle();
    check_eq("t4_caps_nofilt", ifc0.caps, 0);
    check_eq("t4_caps_filtered", ifc1.caps, 1);
    check_eq("t4_count0", ifc0.evt_count, 4);
    check_eq("t4_count1", ifc1.evt_count, 3);
    drain(6);
    exp1.push_back(ev(1'b0, 1'b0, 8'h12)); exp1.push_back(ev(1'b0, 1'b0, 8'h58)); exp1.push_back(ev(1'b0, 1'b1, 8'h12));
    exp0.push_back(ev(1'b0, 1'b0, 8'h12)); exp0.push_back(ev(1'b0, 1'b0, 8'h58));
    exp0.push_back(ev(1'b0, 1'b1, 8'h12)); exp0.push_back(ev(1'b0, 1'b0, 8'h58));
    check_events("t4");

    // overflow: DEPTH+2 makes with nobody reading
    for (int i = 1; i <= DEPTH + 2; i++) send(8'(i));
    settle();
    check_eq("t5_count_full", ifc1.evt_count, DEPTH);
    check_eq("t5_ovf", {ifc1.ovf, ifc0.ovf}, 2'b11);
    drain(DEPTH + 2);
    for (int i = 1; i <= DEPTH; i++) begin
      exp1.push_back(ev(1'b0, 1'b0, 8'(i)));
      exp0.push_back(ev(1'b0, 1'b0, 8'(i)));
    end
    check_events("t5");
    clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
    check_eq("t5_ovf_cleared", ifc1.ovf, 0);

    // full FIFO with pop and push in the same cycle
    for (int i = 0; i < DEPTH; i++) send(8'h21 + 8'(i));
    settle();
    check_eq("t6_full", ifc1.evt_count, DEPTH);
    send(8'h29);
    wait_pop();
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check_eq("t6_count_kept", ifc1.evt_count, DEPTH);
    check_eq("t6_ovf_kept", {ifc1.ovf, ifc0.ovf}, 2'b00);
    drain(DEPTH + 2);
    for (int i = 0; i <= DEPTH; i++) begin
      exp1.push_back(ev(1'b0, 1'b0, 8'h21 + 8'(i)));
      exp0.push_back(ev(1'b0, 1'b0, 8'h21 + 8'(i)));
    end
    check_events("t6");

    // kb_overflow sets ovf and wins over a simultaneous clear
    kb_overflow = 1'b1; tick(1); kb_overflow = 1'b0;
    check_eq("t7_kbovf", ifc1.ovf, 1);
    kb_overflow = 1'b1; clr_ovf = 1'b1; tick(1); kb_overflow = 1'b0;
    check_eq("t7_set_wins", ifc1.ovf, 1);
    tick(1); clr_ovf = 1'b0;
    check_eq("t7_clear", ifc1.ovf, 0);

    // reset in the middle of a pop, after an E0 prefix
    send(8'h12); settle();
    check_eq("t8_pre_shift", ifc1.shift, 1);
    send(8'hE0); settle();
    send(8'h75);
    wait_pop();
    clrn = 1'b0;
    tick(1);
    check_eq("t8_nd", ifc1.kb_nextdata_n, 1);
    check_eq("t8_count", {ifc1.evt_valid, ifc1.evt_count}, 0);
    check_eq("t8_mods", {ifc1.shift, ifc1.ctrl, ifc1.caps, ifc1.ovf}, 0);
    check_eq("t8_head", {ifc1.evt_ext, ifc1.evt_brk, ifc1.evt_code}, 0);
    clrn = 1'b1;
    tick(2);
    got1.delete(); got0.delete();
    send(8'h1C); settle();
    drain(2);
    exp1.push_back(ev(1'b0, 1'b0, 8'h1C)); exp0.push_back(ev(1'b0, 1'b0, 8'h1C));
    check_events("t8");

    check_eq("nextdata_single_pulse", nd_double, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
